id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage RISC-V core.
- Captures the decoder's control bits plus operands/immediates and presents them registered to EX.
- Detects load-use hazards and inserts bubbles; applies branch/jump flushes from EX.
- Sequences the HALT instruction through a drain state machine that freezes fetch and lets older instructions retire.

Parameters:
- DATA_W, 32, operand/PC/immediate width
- REG_AW, 5, register index width
- DRAIN_CYCLES, 3, cycles after HALT acceptance before halted_o asserts (EX+MEM+WB retire)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_jalrsel, id_halt  in  1 each  decoder control bits
- id_aluop  in  2  decoder ALU op class
- id_pc, id_rd1, id_rd2, id_imm  in  DATA_W each  PC, register reads, immediate
- id_rs1, id_rs2, id_rd  in  REG_AW each  register indices
- id_funct3  in  3 / id_funct7  in  7  ALU-control fields
- ex_flush  in  1  EX resolved taken branch/jump; kill ID instruction
- ex_valid  out  1  EX slot holds a real instruction
- ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jalrsel  out  1 each  registered controls
- ex_aluop  out  2
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  DATA_W
- ex_rs1, ex_rs2, ex_rd  out  REG_AW
- ex_funct3  out  3 / ex_funct7  out  7
- stall_o  out  1  freeze PC and IF/ID (combinational)
- halted_o  out  1  core halted (registered)

Behaviour:
- Reset (sync): ex_valid=0; all ex_* controls and ex_aluop=0; ex_* data/index fields=0; state=RUN; drain counter=0; halted_o=0.
- Load-use hazard (combinational): lu = ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- stall_o = (lu & ~ex_flush) | state!=RUN.
- Per-edge priority: reset > ex_flush > stall/state!=RUN > normal.
- Bubble (flush, lu, or state!=RUN): next ex_valid=0, all ex_ controls 0, ex_aluop=0; data/index fields hold their previous values.
- Normal: all id_* fields copied to ex_*, ex_valid=id_valid. Controls are gated with id_valid, so all controls are 0 when id_valid=0. Latency 1 cycle.
- Flush with lu in the same cycle: flush wins, stall_o=0 that cycle.
- HALT acceptance: state==RUN & id_valid & id_halt & ~ex_flush & ~lu.
  - HALT enters EX as a bubble (ex_valid=0).
  - state->DRAIN, counter=DRAIN_CYCLES.
  - A HALT killed by ex_flush is never accepted.
- DRAIN: stall_o=1, bubbles issued, counter decrements each cycle; when counter==1 the next state is HALTED. ex_flush ignored.
- HALTED: stall_o=1, halted_o=1, bubbles forever; exit only via reset.
- DRAIN_CYCLES=1: HALTED one cycle after DRAIN entry. halted_o rises exactly DRAIN_CYCLES+1 edges after the acceptance edge.
- Reset mid-DRAIN/HALTED: back to RUN, halted_o=0 next edge.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds outputs stall_cnt (32) and flush_cnt (32), both reset to 0.
  - stall_cnt increments on each edge where lu & ~ex_flush & state==RUN.
  - flush_cnt increments on each edge where ex_flush & state==RUN.
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Normal pass-through: id_valid=1, R-type (regwrite=1, aluop=10), id_rd1=0x11, id_rd2=0x22, id_rd=5 -> next cycle ex_valid=1, ex_regwrite=1, ex_aluop=2'b10, ex_rd1=0x11, ex_rd=5; stall_o=0.
- Load-use: EX holds lw x7 (memread=1, rd=7); ID add rs1=7 -> stall_o=1 for one cycle, bubble (ex_valid=0, controls 0); add enters EX next cycle, stall_o=0. Repeat with rd=0 -> no stall.
- Flush beats stall: lw rd=3 in EX, ID rs2=3, ex_flush=1 same cycle -> stall_o=0, next ex_valid=0, all controls 0.
- Halt drain, DRAIN_CYCLES=3: accept HALT at edge N -> stall_o=1 from N onward, halted_o=1 at edge N+4, ex_valid=0 throughout; then reset -> halted_o=0, stall_o=0.
- Flushed halt: id_halt=1 with ex_flush=1 -> state stays RUN, halted_o never asserts, no stall.
- Perf counters (macro defined): 2 load-use stalls + 3 flushes -> stall_cnt=2, flush_cnt=3; after reset both 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Registers decoder controls and operands into EX, inserts bubbles on
// load-use hazards and EX flushes, and drains the pipe on HALT.
// Optional performance counters: define ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_alusrc,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic              id_jalrsel,
    input  logic              id_halt,
    input  logic [1:0]        id_aluop,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              ex_flush,
    output logic              ex_valid,
    output logic              ex_alusrc,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_jalrsel,
    output logic [1:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall_o,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              halted_o
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] drain_cnt;
    logic             lu;
    logic             halt_acc;
    logic             bubble;

    // Load in EX whose destination is read by the instruction in ID.
    assign lu = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign stall_o  = (lu & ~ex_flush) | (state != RUN);
    // A HALT is taken only when it would otherwise have issued normally.
    assign halt_acc = (state == RUN) & id_valid & id_halt & ~ex_flush & ~lu;
    // HALT itself travels into EX as a bubble.
    assign bubble   = ex_flush | lu | (state != RUN) | halt_acc;

    // Control bits: cleared on bubble, gated by id_valid otherwise.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ex_valid    <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_jalrsel  <= 1'b0;
            ex_aluop    <= 2'b00;
        end else begin
            ex_valid    <= id_valid;
            ex_alusrc   <= id_alusrc   & id_valid;
            ex_memtoreg <= id_memtoreg & id_valid;
            ex_regwrite <= id_regwrite & id_valid;
            ex_memread  <= id_memread  & id_valid;
            ex_memwrite <= id_memwrite & id_valid;
            ex_branch   <= id_branch   & id_valid;
            ex_jalrsel  <= id_jalrsel  & id_valid;
            ex_aluop    <= id_aluop & {2{id_valid}};
        end
    end

    // Data and index fields hold across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_pc     <= '0;
            ex_rd1    <= '0;
            ex_rd2    <= '0;
            ex_imm    <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_funct3 <= '0;
            ex_funct7 <= '0;
        end else if (!bubble) begin
            ex_pc     <= id_pc;
            ex_rd1    <= id_rd1;
            ex_rd2    <= id_rd2;
            ex_imm    <= id_imm;
            ex_rs1    <= id_rs1;
            ex_rs2    <= id_rs2;
            ex_rd     <= id_rd;
            ex_funct3 <= id_funct3;
            ex_funct7 <= id_funct7;
        end
    end

    // HALT sequencing: RUN -> DRAIN (count down) -> HALTED until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_acc) begin
                        state     <= DRAIN;
                        drain_cnt <= CNT_W'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == CNT_W'(1))
                        state <= HALTED;
                    drain_cnt <= drain_cnt - CNT_W'(1);
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    // halted_o trails entry into HALTED by one edge.
    always_ff @(posedge clk) begin
        if (reset) halted_o <= 1'b0;
        else       halted_o <= (state == HALTED);
    end

`ifdef ID_EX_PERF_CNT_EN
    // Saturating counts of load-use stalls and flushes seen while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu && !ex_flush && state == RUN && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (ex_flush && state == RUN && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use, flush priority,
// flushed HALT, HALT drain/reset, and perf counters when ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread;
    logic        id_memwrite, id_branch, id_jalrsel, id_halt;
    logic [1:0]  id_aluop;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        ex_flush;
    logic        ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
    logic        ex_memwrite, ex_branch, ex_jalrsel;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        stall_o, halted_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_jalrsel(id_jalrsel), .id_halt(id_halt),
        .id_aluop(id_aluop), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_jalrsel(ex_jalrsel), .ex_aluop(ex_aluop),
        .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .stall_o(stall_o),
`ifdef ID_EX_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread} = '0;
        {id_memwrite, id_branch, id_jalrsel, id_halt} = '0;
        id_aluop = 2'b00; id_pc = 32'h0; id_rd1 = 32'h0; id_rd2 = 32'h0; id_imm = 32'h0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_funct3 = 3'd0; id_funct7 = 7'd0;
        ex_flush = 1'b0;
    endtask

    task automatic drive_lw(input logic [4:0] rd);
        idle();
        id_valid = 1'b1; id_alusrc = 1'b1; id_memtoreg = 1'b1; id_regwrite = 1'b1;
        id_memread = 1'b1; id_rs1 = 5'd1; id_rd = rd; id_imm = 32'h10;
    endtask

    task automatic drive_add(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] a);
        idle();
        id_valid = 1'b1; id_regwrite = 1'b1; id_aluop = 2'b10;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd1 = a; id_rd2 = 32'h22;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("rst_rd1", ex_rd1, 32'd0);
        chk("rst_halted", {31'd0, halted_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);

        // Normal R-type pass-through
        drive_add(5'd1, 5'd2, 5'd5, 32'h11);
        id_pc = 32'h100; id_funct3 = 3'd0; id_funct7 = 7'h20;
        #1 chk("norm_stall", {31'd0, stall_o}, 32'd0);
        step();
        chk("norm_valid", {31'd0, ex_valid}, 32'd1);
        chk("norm_regwrite", {31'd0, ex_regwrite}, 32'd1);
        chk("norm_aluop", {30'd0, ex_aluop}, 32'd2);
        chk("norm_rd1", ex_rd1, 32'h11);
        chk("norm_rd2", ex_rd2, 32'h22);
        chk("norm_rd", {27'd0, ex_rd}, 32'd5);
        chk("norm_pc", ex_pc, 32'h100);
        chk("norm_f7", {25'd0, ex_funct7}, 32'h20);

        // Load-use: lw x7 then add rs1=7
        drive_lw(5'd7);
        step();
        chk("lw_memread", {31'd0, ex_memread}, 32'd1);
        drive_add(5'd7, 5'd2, 5'd8, 32'h33);
        #1 chk("lu_stall", {31'd0, stall_o}, 32'd1);
        step();
        chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bub_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("lu_bub_memread", {31'd0, ex_memread}, 32'd0);
        chk("lu_bub_rd_hold", {27'd0, ex_rd}, 32'd7);
        chk("lu_release", {31'd0, stall_o}, 32'd0);
        step();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd8);
        chk("lu_add_rd1", ex_rd1, 32'h33);

        // Load to x0 never stalls
        drive_lw(5'd0);
        step();
        drive_add(5'd0, 5'd2, 5'd8, 32'h44);
        #1 chk("x0_nostall", {31'd0, stall_o}, 32'd0);
        step();
        chk("x0_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("x0_add_rd1", ex_rd1, 32'h44);

        // Second load-use, via rs2
        drive_lw(5'd9);
        step();
        drive_add(5'd1, 5'd9, 5'd10, 32'h55);
        #1 chk("lu2_stall", {31'd0, stall_o}, 32'd1);
        step();
        chk("lu2_bub_valid", {31'd0, ex_valid}, 32'd0);
        step();
        chk("lu2_add_rd", {27'd0, ex_rd}, 32'd10);

        // Flush beats stall
        drive_lw(5'd3);
        step();
        drive_add(5'd1, 5'd3, 5'd11, 32'h66);
        ex_flush = 1'b1;
        #1 chk("fl_stall", {31'd0, stall_o}, 32'd0);
        step();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("fl_memread", {31'd0, ex_memread}, 32'd0);
        chk("fl_rd_hold", {27'd0, ex_rd}, 32'd3);

        // Plain flush of a valid instruction
        drive_add(5'd1, 5'd2, 5'd12, 32'h77);
        ex_flush = 1'b1;
        step();
        chk("fl2_valid", {31'd0, ex_valid}, 32'd0);

        // Flushed HALT is never accepted
        idle();
        id_valid = 1'b1; id_halt = 1'b1; ex_flush = 1'b1;
        step();
        idle();
        #1 chk("fhalt_stall", {31'd0, stall_o}, 32'd0);
        step(); step(); step(); step(); step();
        chk("fhalt_halted", {31'd0, halted_o}, 32'd0);
        chk("fhalt_stall2", {31'd0, stall_o}, 32'd0);

        // HALT drain: acceptance at edge N, halted_o at N+4
        idle();
        id_valid = 1'b1; id_halt = 1'b1;
        #1 chk("h_pre_stall", {31'd0, stall_o}, 32'd0);
        step();                                   // edge N
        drive_add(5'd1, 5'd2, 5'd13, 32'h88);     // must not enter EX
        chk("h_n_stall", {31'd0, stall_o}, 32'd1);
        chk("h_n_valid", {31'd0, ex_valid}, 32'd0);
        chk("h_n_halted", {31'd0, halted_o}, 32'd0);
        ex_flush = 1'b1;                          // ignored while draining
        step();                                   // N+1
        ex_flush = 1'b0;
        chk("h_n1_halted", {31'd0, halted_o}, 32'd0);
        chk("h_n1_valid", {31'd0, ex_valid}, 32'd0);
        step();                                   // N+2
        chk("h_n2_halted", {31'd0, halted_o}, 32'd0);
        step();                                   // N+3
        chk("h_n3_halted", {31'd0, halted_o}, 32'd0);
        chk("h_n3_stall", {31'd0, stall_o}, 32'd1);
        step();                                   // N+4
        chk("h_n4_halted", {31'd0, halted_o}, 32'd1);
        chk("h_n4_valid", {31'd0, ex_valid}, 32'd0);
        chk("h_n4_regwrite", {31'd0, ex_regwrite}, 32'd0);
        step(); step();
        chk("h_hold_halted", {31'd0, halted_o}, 32'd1);
        chk("h_hold_stall", {31'd0, stall_o}, 32'd1);
`ifdef ID_EX_PERF_CNT_EN
        chk("pc_stall_cnt", stall_cnt, 32'd2);
        chk("pc_flush_cnt", flush_cnt, 32'd3);
`endif

        // Reset out of HALTED
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("hr_halted", {31'd0, halted_o}, 32'd0);
        chk("hr_stall", {31'd0, stall_o}, 32'd0);
        chk("hr_valid", {31'd0, ex_valid}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("pc_rst_stall", stall_cnt, 32'd0);
        chk("pc_rst_flush", flush_cnt, 32'd0);
`endif
        drive_add(5'd1, 5'd2, 5'd14, 32'h99);
        step();
        chk("hr_run_valid", {31'd0, ex_valid}, 32'd1);
        chk("hr_run_rd1", ex_rd1, 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
